// File: rtl/idct_zigzag_row_packer_if.sv
// idct_zigzag_row_packer_if: AXI-stream bundle with master/slave views
interface idct_zigzag_row_packer_if #(parameter int W = 12);
  logic [W-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/idct_zigzag_row_packer.sv
// idct_zigzag_row_packer: ping-pong zigzag-to-raster reorder emitting one 8-coefficient row per beat
module idct_zigzag_row_packer #(
  parameter int WIN = 12,
  parameter bit USE_TLAST = 1'b1
) (
  input logic clock,
  input logic reset,
  idct_zigzag_row_packer_if.slave slave,
  idct_zigzag_row_packer_if.master master,
  output logic protocol_err
);
  localparam logic [5:0] zz [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_d;
  logic [WIN-1:0] mem [2][64];
  logic [63:0] mask [2];
  logic [1:0] full;
  logic wb, rb, rb_d, rel, acc, close, tvalid, tvalid_d;
  logic [5:0] k;
  logic [2:0] row, row_d;
  logic [8*WIN-1:0] tdata, tdata_d;
  function automatic logic [8*WIN-1:0] row_of(input logic b, input logic [2:0] r);
    row_of = '0;
    for (int c = 0; c < 8; c++)
      row_of[(7-c)*WIN +: WIN] = mask[b][{r, 3'(c)}] ? mem[b][{r, 3'(c)}] : '0;
  endfunction
  assign slave.tready = ~reset & ~full[wb];
  assign acc = slave.tvalid & slave.tready;
  assign close = acc & ((k == 6'd63) | (USE_TLAST & slave.tlast));
  assign master.tdata = tdata;
  assign master.tvalid = tvalid;
  assign master.tlast = tvalid & (row == 3'd7);
  always_comb begin
    state_d = state;
    rb_d = rb;
    row_d = row;
    tvalid_d = tvalid;
    tdata_d = tdata;
    rel = 1'b0;
    if (state == IDLE) begin
      if (full[rb]) begin
        state_d = STREAM;
        tvalid_d = 1'b1;
        row_d = 3'd0;
        tdata_d = row_of(rb, 3'd0);
      end
    end else if (tvalid & master.tready) begin
      if (row != 3'd7) begin
        row_d = row + 3'd1;
        tdata_d = row_of(rb, row + 3'd1);
      end else begin
        rel = 1'b1;
        rb_d = ~rb;
        row_d = 3'd0;
        if (full[~rb]) begin
          tdata_d = row_of(~rb, 3'd0);
        end else begin
          tvalid_d = 1'b0;
          state_d = IDLE;
        end
      end
    end
  end
  always_ff @(posedge clock) begin
    if (acc) begin
      mem[wb][zz[k]] <= slave.tdata;
      mask[wb] <= (k == 6'd0 ? 64'd0 : mask[wb]) | (64'd1 << zz[k]);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      full <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
      k <= '0;
      row <= '0;
      tvalid <= 1'b0;
      tdata <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_d;
      rb <= rb_d;
      row <= row_d;
      tvalid <= tvalid_d;
      tdata <= tdata_d;
      protocol_err <= USE_TLAST & acc & (k == 6'd63) & ~slave.tlast;
      full <= (full | (2'(close) << wb)) & ~(2'(rel) << rb);
      k <= close ? 6'd0 : acc ? k + 6'd1 : k;
      wb <= close ? ~wb : wb;
    end
  end
endmodule

// File: tb/tb_idct_zigzag_row_packer.sv
// tb_idct_zigzag_row_packer: directed vectors plus randomized traffic against a block-level model
module tb_idct_zigzag_row_packer;
  localparam int W = 12;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic protocol_err;
  bit rand_mode = 1'b0;
  logic mready_fixed = 1'b1;
  logic rnd_ready = 1'b1;
  always #5 clock = ~clock;
  idct_zigzag_row_packer_if #(.W(W)) s();
  idct_zigzag_row_packer_if #(.W(8*W)) m();
  assign m.tready = rand_mode ? rnd_ready : mready_fixed;
  always @(posedge clock) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end
  idct_zigzag_row_packer #(.WIN(W), .USE_TLAST(1'b1)) dut (
    .clock(clock),
    .reset(reset),
    .slave(s),
    .master(m),
    .protocol_err(protocol_err)
  );
  typedef struct {
    logic [8*W-1:0] d;
    bit last;
  } row_t;
  typedef struct {
    string name;
    int n;
    bit last;
    logic [64*W-1:0] vals;
    logic [8*W-1:0] row0, row1, row7;
    int perr;
  } vec_t;
  row_t exp_q[$];
  row_t e;
  logic [W-1:0] cur[$];
  int zz_tb[64];
  int n_checks = 0;
  int n_fail = 0;
  int perr_cnt = 0;
  bit perr_exp = 1'b0;
  bit prev_stall = 1'b0;
  logic [8*W-1:0] prev_data;
  logic prev_last;
  vec_t vecs[4];
  task automatic check(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask
  // zigzag order derived by walking anti-diagonals, alternating direction
  task automatic build_zz();
    int k = 0;
    for (int d = 0; d < 15; d++) begin
      int lo = d > 7 ? d - 7 : 0;
      int hi = d < 7 ? d : 7;
      for (int j = 0; j <= hi - lo; j++) begin
        int r = (d % 2 == 0) ? hi - j : lo + j;
        zz_tb[k] = r * 8 + (d - r);
        k++;
      end
    end
  endtask
  task automatic close_block();
    logic [W-1:0] r[64];
    row_t x;
    for (int i = 0; i < 64; i++) r[i] = '0;
    for (int i = 0; i < cur.size(); i++) r[zz_tb[i]] = cur[i];
    for (int y = 0; y < 8; y++) begin
      for (int c = 0; c < 8; c++) x.d[(7-c)*W +: W] = r[y*8+c];
      x.last = (y == 7);
      exp_q.push_back(x);
    end
    cur.delete();
  endtask
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      cur.delete();
      perr_exp = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("protocol_err", 96'(protocol_err), 96'(perr_exp));
      if (protocol_err) perr_cnt++;
      perr_exp = 1'b0;
      if (prev_stall) begin
        check("hold_tvalid", 96'(m.tvalid), 96'(1));
        check("hold_tdata", m.tdata, prev_data);
        check("hold_tlast", 96'(m.tlast), 96'(prev_last));
      end
      if (s.tvalid && s.tready) begin
        cur.push_back(s.tdata);
        if (s.tlast || cur.size() == 64) begin
          perr_exp = (cur.size() == 64) && !s.tlast;
          close_block();
        end
      end
      if (m.tvalid && m.tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_row: got %h, want none", m.tdata);
        end else begin
          e = exp_q.pop_front();
          check("row_data", m.tdata, e.d);
          check("row_last", 96'(m.tlast), 96'(e.last));
        end
      end
      prev_stall = m.tvalid && !m.tready;
      prev_data = m.tdata;
      prev_last = m.tlast;
    end
  end
  task automatic sync();
    @(posedge clock);
    #1;
  endtask
  task automatic send_beat(input logic [W-1:0] d, input bit l);
    int t = 0;
    s.tdata = d;
    s.tlast = l;
    s.tvalid = 1'b1;
    @(negedge clock);
    while (!s.tready && t < 1000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL slave_tready_wait: got 0, want 1");
    end
    @(posedge clock);
    #1;
    s.tvalid = 1'b0;
    s.tlast = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    s.tvalid = 1'b0;
    s.tlast = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    int p0 = perr_cnt;
    logic [8*W-1:0] rows[8];
    logic [7:0] lasts;
    mready_fixed = 1'b1;
    for (int k = 0; k < v.n; k++) send_beat(v.vals[k*W +: W], v.last && (k == v.n - 1));
    for (int r = 0; r < 8; r++) begin
      int t = 0;
      @(negedge clock);
      while (!m.tvalid && t < 200) begin
        @(negedge clock);
        t++;
      end
      check({v.name, " valid"}, 96'(m.tvalid), 96'(1));
      rows[r] = m.tdata;
      lasts[r] = m.tlast;
    end
    check({v.name, " row0"}, rows[0], v.row0);
    check({v.name, " row1"}, rows[1], v.row1);
    check({v.name, " row7"}, rows[7], v.row7);
    check({v.name, " tlast"}, 96'(lasts), 96'(8'h80));
    check({v.name, " perr"}, 96'(perr_cnt - p0), 96'(v.perr));
    sync();
  endtask
  function automatic logic [8*W-1:0] r8(input int c0, c1, c2, c3, c4, c5, c6, c7);
    return {12'(c0), 12'(c1), 12'(c2), 12'(c3), 12'(c4), 12'(c5), 12'(c6), 12'(c7)};
  endfunction
  initial begin
    int seen;
    build_zz();
    s.tvalid = 1'b0;
    s.tlast = 1'b0;
    s.tdata = '0;
    vecs[0] = '{"full", 64, 1'b1, '0, r8(0, 1, 5, 6, 14, 15, 27, 28),
                r8(2, 4, 7, 13, 16, 26, 29, 42), r8(35, 36, 48, 49, 57, 58, 62, 63), 0};
    vecs[1] = '{"eob3", 3, 1'b1, '0, r8(100, -5, 0, 0, 0, 0, 0, 0),
                r8(7, 0, 0, 0, 0, 0, 0, 0), '0, 0};
    vecs[2] = '{"no_tlast", 64, 1'b0, '0, r8(63, 62, 58, 57, 49, 48, 36, 35),
                r8(61, 59, 56, 50, 47, 37, 34, 21), r8(28, 27, 15, 14, 6, 5, 1, 0), 1};
    vecs[3] = '{"eob1_min", 1, 1'b1, '0, r8(-2048, 0, 0, 0, 0, 0, 0, 0), '0, '0, 0};
    for (int k = 0; k < 64; k++) begin
      vecs[0].vals[k*W +: W] = 12'(k);
      vecs[2].vals[k*W +: W] = 12'(63 - k);
    end
    vecs[1].vals[W-1:0] = 12'd100;
    vecs[1].vals[2*W-1:W] = 12'(-5);
    vecs[1].vals[3*W-1:2*W] = 12'd7;
    vecs[3].vals[W-1:0] = 12'h800;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_slave_tready", 96'(s.tready), 96'(0));
    check("rst_tvalid", 96'(m.tvalid), 96'(0));
    check("rst_tdata", m.tdata, '0);
    check("rst_tlast", 96'(m.tlast), 96'(0));
    check("rst_perr", 96'(protocol_err), 96'(0));
    sync();
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_slave_tready", 96'(s.tready), 96'(1));
    sync();
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);
    mready_fixed = 1'b0;
    for (int k = 0; k < 128; k++) send_beat(12'($urandom), (k % 64) == 63);
    @(negedge clock);
    check("bp_slave_tready", 96'(s.tready), 96'(0));
    check("bp_tvalid", 96'(m.tvalid), 96'(1));
    check("bp_row0", m.tdata, exp_q.size() > 0 ? exp_q[0].d : '0);
    repeat (5) @(negedge clock);
    check("bp_row0_held", m.tdata, exp_q.size() > 0 ? exp_q[0].d : '0);
    sync();
    mready_fixed = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      check("bp_no_gap", 96'(m.tvalid), 96'(1));
      check("bp_tlast", 96'(m.tlast), 96'(i % 8 == 7));
    end
    sync();
    for (int k = 0; k < 30; k++) send_beat(12'(k + 1), 1'b0);
    do_reset();
    @(negedge clock);
    check("rstA_tvalid", 96'(m.tvalid), 96'(0));
    check("rstA_slave_tready", 96'(s.tready), 96'(1));
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      seen += int'(m.tvalid);
    end
    check("rstA_no_stale", 96'(seen), 96'(0));
    sync();
    run_vec(vecs[0]);
    mready_fixed = 1'b0;
    for (int k = 0; k < 64; k++) send_beat(12'($urandom), k == 63);
    seen = 0;
    while (!m.tvalid && seen < 20) begin
      @(negedge clock);
      seen++;
    end
    sync();
    mready_fixed = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    mready_fixed = 1'b0;
    do_reset();
    @(negedge clock);
    check("rstB_tvalid", 96'(m.tvalid), 96'(0));
    check("rstB_tdata", m.tdata, '0);
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      seen += int'(m.tvalid);
    end
    check("rstB_no_stale", 96'(seen), 96'(0));
    sync();
    run_vec(vecs[1]);
    run_vec(vecs[3]);
    rand_mode = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      int len = int'($urandom_range(1, 64));
      bit l64 = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) sync();
        send_beat(12'($urandom), (k == len - 1) && (len < 64 || l64));
      end
    end
    rand_mode = 1'b0;
    mready_fixed = 1'b1;
    seen = 0;
    while ((exp_q.size() != 0 || m.tvalid) && seen < 2000) begin
      @(negedge clock);
      seen++;
    end
    check("drain_empty", 96'(exp_q.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
